// File: rtl/axi_wr_burst_sched_if.sv
// rtl/axi_wr_burst_sched_if.sv - job-control and write-engine handshake bundle for axi_wr_burst_sched
interface axi_wr_burst_sched_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter int C_TOTAL_LEN_WIDTH  = 16
) ();
  // job side
  logic                          I_job_valid;
  logic                          O_job_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0] I_job_addr;
  logic [C_TOTAL_LEN_WIDTH-1:0]  I_job_len;
  logic [C_TOTAL_LEN_WIDTH-1:0]  I_job_ram_base;
  logic                          O_job_done;
  logic                          O_job_err;
  logic                          O_busy;
  // engine side
  logic                          O_ap_start;
  logic                          I_ap_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0] O_base_addr;
  logic [C_RAM_ADDR_WIDTH-1:0]   O_len;
  logic [C_TOTAL_LEN_WIDTH-1:0]  O_ram_base;
  logic [C_TOTAL_LEN_WIDTH-1:0]  O_burst_cnt;

  // scheduler view
  modport slave (
    input  I_job_valid, I_job_addr, I_job_len, I_job_ram_base, I_ap_done,
    output O_job_ready, O_job_done, O_job_err, O_busy, O_ap_start,
           O_base_addr, O_len, O_ram_base, O_burst_cnt
  );

  // job controller / engine view
  modport master (
    output I_job_valid, I_job_addr, I_job_len, I_job_ram_base, I_ap_done,
    input  O_job_ready, O_job_done, O_job_err, O_busy, O_ap_start,
           O_base_addr, O_len, O_ram_base, O_burst_cnt
  );
endinterface

// File: rtl/axi_wr_burst_sched.sv
// rtl/axi_wr_burst_sched.sv - splits a write-back job into 4KB-safe AXI bursts; optional watchdog via AXI_WR_SCHED_WATCHDOG_EN
module axi_wr_burst_sched #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter int C_TOTAL_LEN_WIDTH  = 16,
  parameter int C_MAX_BURST        = 16,
  parameter int C_TIMEOUT_CYC      = 4096
) (
  input logic                    I_clk,
  input logic                    I_rst,
  axi_wr_burst_sched_if.slave    bus
);

  localparam int AW      = C_M_AXI_ADDR_WIDTH;
  localparam int RW      = C_RAM_ADDR_WIDTH;
  localparam int TW      = C_TOTAL_LEN_WIDTH;
  localparam int BPB     = C_M_AXI_DATA_WIDTH / 8;
  localparam int BPB_LOG = $clog2(BPB);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  // Reject parameter sets the burst arithmetic cannot represent.
  if (C_MAX_BURST < 1 || C_MAX_BURST > (1 << C_RAM_ADDR_WIDTH) - 1) begin : g_bad_max_burst
    $error("C_MAX_BURST out of range");
  end
  if (C_TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("C_TIMEOUT_CYC must be at least 1");
  end

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [AW-1:0] addr_q;
  logic [TW-1:0] remaining;
  logic [TW-1:0] ram_base_q;
  logic [TW-1:0] burst_cnt_q;
  logic [AW-1:0] base_addr_q;
  logic [RW-1:0] len_q;
  logic [TW-1:0] ram_out_q;
  logic          job_ready_q;
  logic          job_done_q;
  logic          job_err_q;
  logic          busy_q;
  logic          ap_start_q;
  logic          accept;
  logic [12:0]   to4k;
  logic [31:0]   burst_calc;
`ifdef AXI_WR_SCHED_WATCHDOG_EN
  logic [31:0]   wd_cnt;
  logic          timeout;
`endif

  assign accept = bus.I_job_valid && job_ready_q;

`ifdef AXI_WR_SCHED_WATCHDOG_EN
  assign timeout = (wd_cnt == 32'(C_TIMEOUT_CYC - 1));
`endif

  // Beats left before the 4KB page boundary, and the clipped burst length.
  always_comb begin
    to4k       = (13'h1000 - {1'b0, addr_q[11:0]}) >> BPB_LOG;
    burst_calc = 32'(remaining);
    if (32'(C_MAX_BURST) < burst_calc) burst_calc = 32'(C_MAX_BURST);
    if ({19'd0, to4k} < burst_calc)    burst_calc = {19'd0, to4k};
  end

  // Next-state selection for the burst sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (bus.I_job_len == '0) ? S_FIN : S_CALC;
      S_CALC: state_nxt = S_RUN;
      S_RUN: begin
        if (bus.I_ap_done) state_nxt = S_GAP;
`ifdef AXI_WR_SCHED_WATCHDOG_EN
        else if (timeout)  state_nxt = S_IDLE;
`endif
      end
      S_GAP:   state_nxt = (remaining == '0) ? S_FIN : S_CALC;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, job bookkeeping and all registered outputs.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      remaining   <= '0;
      ram_base_q  <= '0;
      burst_cnt_q <= '0;
      base_addr_q <= '0;
      len_q       <= '0;
      ram_out_q   <= '0;
      job_ready_q <= 1'b1;
      job_done_q  <= 1'b0;
      job_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      ap_start_q  <= 1'b0;
`ifdef AXI_WR_SCHED_WATCHDOG_EN
      wd_cnt      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      job_ready_q <= (state_nxt == S_IDLE);
      busy_q      <= (state_nxt != S_IDLE);
      ap_start_q  <= (state_nxt == S_RUN);
      job_done_q  <= (state == S_FIN);
`ifdef AXI_WR_SCHED_WATCHDOG_EN
      // A completion arriving with the timeout wins and is not an error.
      job_err_q   <= (state == S_RUN) && !bus.I_ap_done && timeout;
`else
      job_err_q   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q      <= bus.I_job_addr;
            remaining   <= bus.I_job_len;
            ram_base_q  <= bus.I_job_ram_base;
            burst_cnt_q <= '0;
          end
        end
        S_CALC: begin
          len_q       <= RW'(burst_calc);
          base_addr_q <= addr_q;
          ram_out_q   <= ram_base_q;
`ifdef AXI_WR_SCHED_WATCHDOG_EN
          wd_cnt      <= '0;
`endif
        end
        S_RUN: begin
          if (bus.I_ap_done) begin
            addr_q      <= addr_q + (AW'(len_q) << BPB_LOG);
            ram_base_q  <= ram_base_q + TW'(len_q);
            remaining   <= remaining - TW'(len_q);
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
`ifdef AXI_WR_SCHED_WATCHDOG_EN
          wd_cnt <= wd_cnt + 32'd1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.O_job_ready = job_ready_q;
  assign bus.O_job_done  = job_done_q;
  assign bus.O_job_err   = job_err_q;
  assign bus.O_busy      = busy_q;
  assign bus.O_ap_start  = ap_start_q;
  assign bus.O_base_addr = base_addr_q;
  assign bus.O_len       = len_q;
  assign bus.O_ram_base  = ram_out_q;
  assign bus.O_burst_cnt = burst_cnt_q;

endmodule

// File: doc/axi_wr_burst_sched.md
Name: axi_wr_burst_sched

Overview:
- Splits one write-back job (RAM base, DDR byte address, total beat count) into AXI-legal bursts.
- Sequences the rambus2axibus write engine through its ap_start/ap_done handshake, one burst at a time.
- Sits between the main_process job control and the RAM-to-AXI engine.
- Enforces the maximum burst length and the AXI 4 KB no-crossing rule, and tracks per-burst DDR and RAM offsets.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, DDR byte address width
C_M_AXI_DATA_WIDTH, 128, AXI data width; bytes per beat BPB = C_M_AXI_DATA_WIDTH/8 (power of 2)
C_RAM_ADDR_WIDTH, 10, engine len/RAM address width
C_TOTAL_LEN_WIDTH, 16, job beat-count width
C_MAX_BURST, 16, max beats per burst; must be ≥1 and ≤ 2^C_RAM_ADDR_WIDTH-1
C_TIMEOUT_CYC, 4096, watchdog limit (optional feature only)

Ports:
I_clk  in  1  clock
I_rst  in  1  synchronous active-high reset
I_job_valid  in  1  job request
O_job_ready  out  1  high in IDLE only
I_job_addr  in  C_M_AXI_ADDR_WIDTH  job DDR byte address, BPB-aligned
I_job_len  in  C_TOTAL_LEN_WIDTH  job beats
I_job_ram_base  in  C_TOTAL_LEN_WIDTH  RAM beat offset of the first beat
O_job_done  out  1  one-cycle pulse at job end
O_job_err  out  1  one-cycle pulse on watchdog abort (tied 0 without the feature)
O_busy  out  1  state != IDLE
O_ap_start  out  1  to engine I_ap_start, level
I_ap_done  in  1  from engine O_ap_done
O_base_addr  out  C_M_AXI_ADDR_WIDTH  burst DDR address, to engine I_base_addr
O_len  out  C_RAM_ADDR_WIDTH  burst beats, to engine I_len
O_ram_base  out  C_TOTAL_LEN_WIDTH  RAM beat offset of the current burst
O_burst_cnt  out  C_TOTAL_LEN_WIDTH  bursts completed in the current job

Behaviour:
- All outputs are registered. Reset values:
  - O_job_ready=1
  - O_job_done=0, O_job_err=0, O_busy=0, O_ap_start=0
  - O_base_addr=0, O_len=0, O_ram_base=0, O_burst_cnt=0
- FSM states: IDLE, CALC, RUN, GAP, FIN.
- IDLE:
  - On I_job_valid && O_job_ready, latch addr, remaining=I_job_len and ram_base; clear O_burst_cnt.
  - If I_job_len==0, go to FIN. Otherwise go to CALC.
  - I_job_valid while not IDLE is ignored.
- CALC (1 cycle):
  - to4k = (4096 - addr[11:0]) / BPB.
  - burst = min(remaining, C_MAX_BURST, to4k).
  - Register O_len=burst, O_base_addr=addr, O_ram_base=ram_base. Go to RUN.
- RUN:
  - O_ap_start=1, asserted exactly 2 cycles after job accept. O_len, O_base_addr and O_ram_base are held stable throughout.
  - On I_ap_done:
    - Drop O_ap_start next cycle.
    - addr += burst*BPB, ram_base += burst, remaining -= burst, O_burst_cnt += 1.
    - Go to GAP.
- GAP (1 cycle):
  - O_ap_start=0, so the engine clears its internal state.
  - Go to FIN if remaining==0, else CALC.
- FIN: O_job_done=1 for one cycle, then IDLE.
- Burst spacing: consecutive bursts have ≥2 cycles of O_ap_start low (GAP plus CALC).
- Addresses wrap modulo 2^C_M_AXI_ADDR_WIDTH. The burst computation is unsigned, with no overflow since burst ≤ remaining.
- I_ap_done outside RUN is ignored.
- Reset mid-operation (I_rst at any state) drops O_ap_start the next cycle and returns to IDLE. The aborted job is not resumed.

Optional Feature:
- Macro: AXI_WR_SCHED_WATCHDOG_EN.
- When defined:
  - A cycle counter runs in RUN and clears on entry to RUN.
  - If it reaches C_TIMEOUT_CYC without I_ap_done: drop O_ap_start, pulse O_job_err one cycle, go to IDLE without pulsing O_job_done.
  - I_ap_done in the same cycle as the timeout takes priority as a normal completion.
- When undefined: no counter exists, O_job_err is constant 0, and RUN waits indefinitely.

Test Plan:
- Job addr=0x1000, len=40, ram_base=0, C_MAX_BURST=16; engine model acks after 30 cycles -> three bursts (0x1000,16,0), (0x1100,16,16), (0x1200,8,32); O_burst_cnt=3; single O_job_done.
- Job addr=0x0FC0, len=16 -> bursts (0x0FC0,4,0), (0x1000,12,4); no burst crosses 4 KB.
- Job len=0 -> O_ap_start never rises; O_job_done 2 cycles after accept.
- I_job_valid pulsed during RUN of an active job -> ignored; O_job_ready=0; active job completes unchanged.
- I_rst asserted in RUN of burst 2 -> next cycle O_ap_start=0, O_busy=0, O_job_ready=1; no O_job_done; a new job then runs from its own base.
- With AXI_WR_SCHED_WATCHDOG_EN, C_TIMEOUT_CYC=64, engine never acks -> O_ap_start drops after 64 RUN cycles; O_job_err pulses; no O_job_done; state IDLE.
